jb_passthru_seq: RTL and testbench

//  Sequences the Joybus man-in-the-middle between console and controller.

---
 rtl/jb_passthru_seq_if.sv | 29 ++
 rtl/jb_passthru_seq.sv | 160 ++++++++++++++++
 tb/tb_jb_passthru_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/jb_passthru_seq_if.sv
// Handshake and enable bundle between the Joybus sequencer and its RX/TX engines and line muxes.
interface jb_passthru_seq_if;
    logic       inject_en;
    logic       console_cmd_done;
    logic       console_did_poll;
    logic       cntlr_data_rdy;
    logic       inject_done;
    logic       reset_cmd_done_status;
    logic       reset_poll_status;
    logic       cntlr_rx_start;
    logic       inject_start;
    logic       console_to_cntlr;
    logic       cntlr_to_console;
    logic       inject_sel;
    logic       timeout_err;
    logic [2:0] state_dbg;

    modport slave (
        input  inject_en, console_cmd_done, console_did_poll, cntlr_data_rdy, inject_done,
        output reset_cmd_done_status, reset_poll_status, cntlr_rx_start, inject_start,
        output console_to_cntlr, cntlr_to_console, inject_sel, timeout_err, state_dbg
    );

    modport master (
        output inject_en, console_cmd_done, console_did_poll, cntlr_data_rdy, inject_done,
        input  reset_cmd_done_status, reset_poll_status, cntlr_rx_start, inject_start,
        input  console_to_cntlr, cntlr_to_console, inject_sel, timeout_err, state_dbg
    );
endinterface

// File: rtl/jb_passthru_seq.sv
// Joybus man-in-the-middle sequencer: forwards console commands, then forwards or
// substitutes the controller reply, owning both line direction enables.
module jb_passthru_seq #(
    parameter int unsigned TURNAROUND = 20,
    parameter int unsigned RESP_TMO   = 25000,
    parameter int unsigned GUARD      = 100,
    parameter int unsigned CNT_W      = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    jb_passthru_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        WAIT_CMD = 3'd0,
        TURN     = 3'd1,
        FWD      = 3'd2,
        CAPTURE  = 3'd3,
        INJECT   = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURNAROUND - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD   = CNT_W'(RESP_TMO - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             poll_inj, poll_inj_nxt;
    logic             rcd_q, rps_q, rxs_q, ist_q, tmo_q;
    logic             rcd_nxt, rps_nxt, rxs_nxt, ist_nxt, tmo_nxt;
    logic             c2c_q, ctc_q, sel_q;
    logic             c2c_nxt, ctc_nxt, sel_nxt;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    // Response pulses take priority over the counter reaching zero, so a reply
    // arriving on the last allowed cycle is treated as success.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        poll_inj_nxt = poll_inj;
        rcd_nxt      = 1'b0;
        rps_nxt      = 1'b0;
        rxs_nxt      = 1'b0;
        ist_nxt      = 1'b0;
        tmo_nxt      = 1'b0;
        case (state)
            WAIT_CMD: begin
                if (bus.console_cmd_done) begin
                    rcd_nxt      = 1'b1;
                    rxs_nxt      = 1'b1;
                    rps_nxt      = bus.console_did_poll;
                    poll_inj_nxt = bus.console_did_poll & bus.inject_en;
                    cnt_nxt      = TURN_LOAD;
                    state_nxt    = TURN;
                end
            end
            TURN: begin
                if (cnt_zero) begin
                    state_nxt = poll_inj ? CAPTURE : FWD;
                    cnt_nxt   = TMO_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            FWD: begin
                if (bus.cntlr_data_rdy) begin
                    state_nxt = DONE;
                    cnt_nxt   = GUARD_LOAD;
                end else if (cnt_zero) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = DONE;
                    cnt_nxt   = GUARD_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            CAPTURE: begin
                if (bus.cntlr_data_rdy) begin
                    ist_nxt   = 1'b1;
                    state_nxt = INJECT;
                    cnt_nxt   = TMO_LOAD;
                end else if (cnt_zero) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = DONE;
                    cnt_nxt   = GUARD_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            INJECT: begin
                if (bus.inject_done) begin
                    state_nxt = DONE;
                    cnt_nxt   = GUARD_LOAD;
                end else if (cnt_zero) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = DONE;
                    cnt_nxt   = GUARD_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                if (cnt_zero) begin
                    state_nxt = WAIT_CMD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_CMD;
                cnt_nxt   = '0;
            end
        endcase

        // Enables follow the next state so they switch on the same edge as the state.
        c2c_nxt = (state_nxt == WAIT_CMD);
        ctc_nxt = (state_nxt == FWD) || (state_nxt == INJECT);
        sel_nxt = (state_nxt == INJECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_CMD;
            cnt      <= '0;
            poll_inj <= 1'b0;
            rcd_q    <= 1'b0;
            rps_q    <= 1'b0;
            rxs_q    <= 1'b0;
            ist_q    <= 1'b0;
            tmo_q    <= 1'b0;
            c2c_q    <= 1'b1;
            ctc_q    <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            poll_inj <= poll_inj_nxt;
            rcd_q    <= rcd_nxt;
            rps_q    <= rps_nxt;
            rxs_q    <= rxs_nxt;
            ist_q    <= ist_nxt;
            tmo_q    <= tmo_nxt;
            c2c_q    <= c2c_nxt;
            ctc_q    <= ctc_nxt;
            sel_q    <= sel_nxt;
        end
    end

    assign bus.reset_cmd_done_status = rcd_q;
    assign bus.reset_poll_status     = rps_q;
    assign bus.cntlr_rx_start        = rxs_q;
    assign bus.inject_start          = ist_q;
    assign bus.timeout_err           = tmo_q;
    assign bus.console_to_cntlr      = c2c_q;
    assign bus.cntlr_to_console      = ctc_q;
    assign bus.inject_sel            = sel_q;
    assign bus.state_dbg             = state;
endmodule

// File: tb/tb_jb_passthru_seq.sv
// Directed bench for jb_passthru_seq with hand-computed cycle counts (RESP_TMO shortened).
module tb_jb_passthru_seq;
    localparam int unsigned TA   = 20;
    localparam int unsigned TMO  = 60;
    localparam int unsigned GRD  = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ist_cnt = 0;

    jb_passthru_seq_if bus ();

    jb_passthru_seq #(
        .TURNAROUND(TA),
        .RESP_TMO(TMO),
        .GUARD(GRD),
        .CNT_W(15)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Continuous invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.inject_start === 1'b1) ist_cnt++;
        if (rst_n) begin
            checks++;
            assert (!(bus.console_to_cntlr === 1'b1 && bus.cntlr_to_console === 1'b1)) else begin
                errors++;
                $error("FAIL both_en: observed c2c=%b ctc=%b expected not both 1",
                       bus.console_to_cntlr, bus.cntlr_to_console);
            end
            checks++;
            assert (bus.inject_sel !== 1'b1 || bus.state_dbg === 3'd4) else begin
                errors++;
                $error("FAIL sel_state: observed state %0d with inject_sel=1 expected 4", bus.state_dbg);
            end
        end
    end

    initial begin
        bus.inject_en        = 1'b0;
        bus.console_cmd_done = 1'b0;
        bus.console_did_poll = 1'b0;
        bus.cntlr_data_rdy   = 1'b0;
        bus.inject_done      = 1'b0;
        ticks(3);
        chk("rst_state", 32'(bus.state_dbg), 0);
        chk("rst_c2c", 32'(bus.console_to_cntlr), 1);
        chk("rst_ctc", 32'(bus.cntlr_to_console), 0);
        chk("rst_sel", 32'(bus.inject_sel), 0);
        chk("rst_tmo", 32'(bus.timeout_err), 0);
        chk("rst_rxs", 32'(bus.cntlr_rx_start), 0);
        rst_n = 1'b1;
        ticks(2);
        chk("idle_state", 32'(bus.state_dbg), 0);

        // Test 1: non-poll command, inject_en=1, stray data_rdy during TURN ignored
        bus.inject_en = 1'b1;
        bus.console_cmd_done = 1'b1;
        tick();
        chk("t1_turn", 32'(bus.state_dbg), 1);
        chk("t1_rcd", 32'(bus.reset_cmd_done_status), 1);
        chk("t1_rxs", 32'(bus.cntlr_rx_start), 1);
        chk("t1_rps", 32'(bus.reset_poll_status), 0);
        chk("t1_c2c_off", 32'(bus.console_to_cntlr), 0);
        bus.console_cmd_done = 1'b0;
        ticks(10);
        bus.cntlr_data_rdy = 1'b1;
        tick();
        bus.cntlr_data_rdy = 1'b0;
        chk("t1_rcd_pulse", 32'(bus.reset_cmd_done_status), 0);
        ticks(8);
        chk("t1_turn_end", 32'(bus.state_dbg), 1);
        tick();
        chk("t1_fwd", 32'(bus.state_dbg), 2);
        chk("t1_fwd_ctc", 32'(bus.cntlr_to_console), 1);
        chk("t1_fwd_sel", 32'(bus.inject_sel), 0);
        ticks(5);
        bus.cntlr_data_rdy = 1'b1;
        tick();
        bus.cntlr_data_rdy = 1'b0;
        chk("t1_done", 32'(bus.state_dbg), 5);
        chk("t1_done_ctc", 32'(bus.cntlr_to_console), 0);
        chk("t1_no_tmo", 32'(bus.timeout_err), 0);
        ticks(GRD - 1);
        chk("t1_guard_end", 32'(bus.state_dbg), 5);
        tick();
        chk("t1_wait", 32'(bus.state_dbg), 0);
        chk("t1_wait_c2c", 32'(bus.console_to_cntlr), 1);
        chk("t1_no_inject", 32'(ist_cnt), 0);

        // Test 2: poll with inject_en=1 -> capture then inject
        bus.console_cmd_done = 1'b1;
        bus.console_did_poll = 1'b1;
        tick();
        chk("t2_turn", 32'(bus.state_dbg), 1);
        chk("t2_rps", 32'(bus.reset_poll_status), 1);
        bus.console_cmd_done = 1'b0;
        bus.console_did_poll = 1'b0;
        ticks(TA);
        chk("t2_capture", 32'(bus.state_dbg), 3);
        chk("t2_cap_c2c", 32'(bus.console_to_cntlr), 0);
        chk("t2_cap_ctc", 32'(bus.cntlr_to_console), 0);
        ticks(3);
        bus.cntlr_data_rdy = 1'b1;
        tick();
        bus.cntlr_data_rdy = 1'b0;
        chk("t2_inject", 32'(bus.state_dbg), 4);
        chk("t2_ist", 32'(bus.inject_start), 1);
        chk("t2_inj_ctc", 32'(bus.cntlr_to_console), 1);
        chk("t2_inj_sel", 32'(bus.inject_sel), 1);
        tick();
        chk("t2_ist_pulse", 32'(bus.inject_start), 0);
        ticks(5);
        chk("t2_sel_hold", 32'(bus.inject_sel), 1);
        bus.inject_done = 1'b1;
        tick();
        bus.inject_done = 1'b0;
        chk("t2_done", 32'(bus.state_dbg), 5);
        chk("t2_sel_off", 32'(bus.inject_sel), 0);
        chk("t2_ist_cnt", 32'(ist_cnt), 1);
        ticks(GRD);
        chk("t2_wait", 32'(bus.state_dbg), 0);

        // Test 3: poll with inject_en=0 -> forward path
        bus.inject_en = 1'b0;
        bus.console_cmd_done = 1'b1;
        bus.console_did_poll = 1'b1;
        tick();
        chk("t3_rps", 32'(bus.reset_poll_status), 1);
        bus.console_cmd_done = 1'b0;
        bus.console_did_poll = 1'b0;
        ticks(TA);
        chk("t3_fwd", 32'(bus.state_dbg), 2);
        bus.cntlr_data_rdy = 1'b1;
        tick();
        bus.cntlr_data_rdy = 1'b0;
        chk("t3_done", 32'(bus.state_dbg), 5);
        ticks(GRD);
        chk("t3_wait", 32'(bus.state_dbg), 0);

        // Test 4: no controller reply -> timeout after TMO cycles in FWD
        bus.console_cmd_done = 1'b1;
        tick();
        bus.console_cmd_done = 1'b0;
        ticks(TA);
        chk("t4_fwd", 32'(bus.state_dbg), 2);
        ticks(TMO - 1);
        chk("t4_pre_tmo_state", 32'(bus.state_dbg), 2);
        chk("t4_pre_tmo", 32'(bus.timeout_err), 0);
        tick();
        chk("t4_tmo", 32'(bus.timeout_err), 1);
        chk("t4_done", 32'(bus.state_dbg), 5);
        tick();
        chk("t4_tmo_pulse", 32'(bus.timeout_err), 0);

        // Test 5: command held during DONE is served on return; coincident data_rdy wins
        bus.inject_en = 1'b1;
        bus.console_cmd_done = 1'b1;
        bus.console_did_poll = 1'b1;
        ticks(GRD - 2);
        chk("t5_held_done", 32'(bus.state_dbg), 5);
        chk("t5_held_rcd", 32'(bus.reset_cmd_done_status), 0);
        tick();
        chk("t5_wait", 32'(bus.state_dbg), 0);
        tick();
        chk("t5_served", 32'(bus.state_dbg), 1);
        chk("t5_served_rcd", 32'(bus.reset_cmd_done_status), 1);
        bus.console_cmd_done = 1'b0;
        bus.console_did_poll = 1'b0;
        ticks(TA);
        chk("t5_capture", 32'(bus.state_dbg), 3);
        ticks(TMO - 1);
        chk("t5_cap_last", 32'(bus.state_dbg), 3);
        bus.cntlr_data_rdy = 1'b1;
        tick();
        bus.cntlr_data_rdy = 1'b0;
        chk("t5_inject", 32'(bus.state_dbg), 4);
        chk("t5_no_tmo", 32'(bus.timeout_err), 0);
        chk("t5_ist", 32'(bus.inject_start), 1);
        ticks(4);

        // Test 6: asynchronous reset mid-INJECT
        chk("t6_in_inject", 32'(bus.inject_sel), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_c2c", 32'(bus.console_to_cntlr), 1);
        chk("t6_ctc", 32'(bus.cntlr_to_console), 0);
        chk("t6_sel", 32'(bus.inject_sel), 0);
        chk("t6_state", 32'(bus.state_dbg), 0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
        chk("t6_idle", 32'(bus.state_dbg), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
